// File: rtl/rr_stream_mux.sv
// rr_stream_mux: NUM_IN-channel valid/ready stream multiplexer with a
// round-robin arbiter and a one-entry registered output stage.
// Optional packet locking is enabled by defining RR_STREAM_MUX_PKT_LOCK_EN:
// once a channel starts a packet, it keeps the grant until in_last.
module rr_stream_mux #(
  parameter  int unsigned N      = 8,
  parameter  int unsigned NUM_IN = 4,
  localparam int unsigned SEL_W  = $clog2(NUM_IN)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_IN*N-1:0]   in_data,
  input  logic [NUM_IN-1:0]     in_valid,
  output logic [NUM_IN-1:0]     in_ready,
  input  logic [NUM_IN-1:0]     in_last,
  output logic [N-1:0]          out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SEL_W-1:0]      out_sel,
  output logic                  out_last
);

  logic [N-1:0]     out_data_q,  out_data_d;
  logic             out_valid_q, out_valid_d;
  logic [SEL_W-1:0] out_sel_q,   out_sel_d;
  logic             out_last_q,  out_last_d;
  logic [SEL_W-1:0] ptr_q,       ptr_d;
`ifdef RR_STREAM_MUX_PKT_LOCK_EN
  logic             lock_q,      lock_d;
  logic [SEL_W-1:0] lock_ch_q,   lock_ch_d;
`endif

  logic             load;
  logic             grant_found;
  logic [SEL_W-1:0] grant_idx;
  logic             accept;
  logic [N-1:0]     sel_beat;
  logic             sel_last;
  int unsigned      cand;

  assign load = !out_valid_q || out_ready;

  // Round-robin search from ptr with wrap; a held lock overrides the search.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      cand = 32'(ptr_q) + k;
      if (cand >= NUM_IN) cand = cand - NUM_IN;
      if (!grant_found && in_valid[SEL_W'(cand)]) begin
        grant_found = 1'b1;
        grant_idx   = SEL_W'(cand);
      end
    end
`ifdef RR_STREAM_MUX_PKT_LOCK_EN
    if (lock_q) begin
      grant_found = in_valid[lock_ch_q];
      grant_idx   = lock_ch_q;
    end
`endif
  end

  assign accept = grant_found && load;

  // One-hot ready and selection of the granted channel's beat.
  always_comb begin
    in_ready = '0;
    sel_beat = '0;
    sel_last = 1'b0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      if (grant_idx == SEL_W'(i)) begin
        in_ready[i] = accept;
        sel_beat    = in_data[i*N +: N];
        sel_last    = in_last[i];
      end
    end
  end

  // Next-state for the output register, priority pointer and lock.
  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_sel_d   = out_sel_q;
    out_last_d  = out_last_q;
    ptr_d       = ptr_q;
`ifdef RR_STREAM_MUX_PKT_LOCK_EN
    lock_d      = lock_q;
    lock_ch_d   = lock_ch_q;
`endif
    if (load) begin
      out_valid_d = accept;
      if (accept) begin
        out_data_d = sel_beat;
        out_sel_d  = grant_idx;
        out_last_d = sel_last;
        ptr_d      = (grant_idx == SEL_W'(NUM_IN - 1)) ? '0 : grant_idx + 1'b1;
`ifdef RR_STREAM_MUX_PKT_LOCK_EN
        lock_d     = !sel_last;
        lock_ch_d  = grant_idx;
`endif
      end
    end
  end

  // State registers with synchronous reset; a beat held at reset is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_sel_q   <= '0;
      out_last_q  <= 1'b0;
      ptr_q       <= '0;
`ifdef RR_STREAM_MUX_PKT_LOCK_EN
      lock_q      <= 1'b0;
      lock_ch_q   <= '0;
`endif
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_sel_q   <= out_sel_d;
      out_last_q  <= out_last_d;
      ptr_q       <= ptr_d;
`ifdef RR_STREAM_MUX_PKT_LOCK_EN
      lock_q      <= lock_d;
      lock_ch_q   <= lock_ch_d;
`endif
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_sel   = out_sel_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_rr_stream_mux.sv
// Scoreboard bench for rr_stream_mux (N=8, NUM_IN=4). The driver keeps a
// behavioural model of the arbiter and pushes each expected output beat;
// a separate monitor pops and compares on every output handshake.
module tb_rr_stream_mux;
  localparam int N  = 8;
  localparam int NI = 4;
`ifdef RR_STREAM_MUX_PKT_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NI*N-1:0] in_data = '0;
  logic [NI-1:0]   in_valid = '0;
  logic [NI-1:0]   in_ready;
  logic [NI-1:0]   in_last = '0;
  logic [N-1:0]    out_data;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [1:0]      out_sel;
  logic            out_last;

  rr_stream_mux #(.N(N), .NUM_IN(NI)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_sel(out_sel), .out_last(out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] d;
    int           sel;
    logic         last;
  } beat_t;

  beat_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: output register occupancy, priority pointer, packet lock.
  bit m_occ;
  int m_ptr;
  bit m_lock;
  int m_lock_ch;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: drive inputs, check ready/valid against the model, predict.
  task automatic step(input logic [NI-1:0] v, input logic [NI*N-1:0] d,
                      input logic [NI-1:0] l, input logic ordy, output int g);
    bit load;
    logic [NI-1:0] exp_rdy;
    @(negedge clk);
    rst = 1'b0; in_valid = v; in_data = d; in_last = l; out_ready = ordy;
    #1;
    chk("out_valid", int'(out_valid), int'(m_occ));
    load = !m_occ || ordy;
    g = -1;
    if (LOCK_EN && m_lock) begin
      if (v[m_lock_ch]) g = m_lock_ch;
    end else begin
      for (int k = 0; k < NI; k++) begin
        int c;
        c = (m_ptr + k) % NI;
        if (g < 0 && v[c]) g = c;
      end
    end
    if (!load) g = -1;
    exp_rdy = (g >= 0) ? NI'(1 << g) : '0;
    chk("in_ready", int'(in_ready), int'(exp_rdy));
    if (g >= 0) begin
      beat_t b;
      b.d = d[g*N +: N]; b.sel = g; b.last = l[g];
      sb.push_back(b);
      m_ptr = (g + 1) % NI;
      m_lock = LOCK_EN && !l[g];
      m_lock_ch = g;
      m_occ = 1'b1;
    end else if (load) begin
      m_occ = 1'b0;
    end
  endtask

  task automatic do_reset(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      rst = 1'b1; in_valid = '0; out_ready = 1'b0;
      #1;
      sb.delete();
      m_occ = 0; m_ptr = 0; m_lock = 0; m_lock_ch = 0;
    end
  endtask

  // Monitor: compare every output handshake with the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_beat", 1, 0);
        end else begin
          beat_t e;
          e = sb.pop_front();
          chk("out_data", int'(out_data), int'(e.d));
          chk("out_sel",  int'(out_sel),  e.sel);
          chk("out_last", int'(out_last), int'(e.last));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    int rem;
    logic [NI*N-1:0] inc_data;
    inc_data = {8'h13, 8'h12, 8'h11, 8'h10};

    // Reset state
    do_reset(2);
    step('0, '0, '0, 1'b1, g);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_sel",  int'(out_sel),  0);
    chk("rst_out_last", int'(out_last), 0);

    // All channels valid, full throughput: 10,11,12,13,10
    for (int i = 0; i < 5; i++) step('1, inc_data, '1, 1'b1, g);
    // Stall for 3 cycles, then release
    for (int i = 0; i < 3; i++) step('1, inc_data, '1, 1'b0, g);
    for (int i = 0; i < 3; i++) step('1, inc_data, '1, 1'b1, g);
    for (int i = 0; i < 2; i++) step('0, '0, '0, 1'b1, g);

    // ptr=2 with only ch1 and ch3 valid: ch3 first, then ch1 by wrap
    do_reset(1);
    step(4'b0001, inc_data, '1, 1'b1, g);
    step(4'b0010, inc_data, '1, 1'b1, g);
    step(4'b1010, inc_data, '1, 1'b1, g);
    step(4'b1010, inc_data, '1, 1'b1, g);
    chk("wrap_last_grant", g, 1);
    step('0, '0, '0, 1'b1, g);

    // ch0 sends a 3-beat packet while ch1 is always valid
    do_reset(1);
    rem = 3;
    for (int i = 0; i < 6; i++) begin
      logic [NI-1:0] v;
      logic [NI-1:0] l;
      v = {2'b00, 1'b1, rem > 0};
      l = {2'b11, 1'b1, rem == 1};
      step(v, inc_data + NI*N'(i), l, 1'b1, g);
      if (g == 0) rem--;
    end
    step('0, '0, '0, 1'b1, g);

    // Reset while a beat is stalled in the output register
    step(4'b0100, inc_data, '1, 1'b1, g);
    step(4'b0100, inc_data, '1, 1'b0, g);
    do_reset(1);
    step('0, '0, '0, 1'b0, g);
    step(4'b1000, inc_data, '1, 1'b1, g);
    chk("post_rst_grant", g, 3);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [NI-1:0] v;
      logic [NI-1:0] l;
      logic [NI*N-1:0] d;
      v = NI'($urandom);
      l = NI'($urandom) & NI'($urandom);
      d = {$urandom};
      step(v, d, l, ($urandom_range(0, 3) != 0), g);
    end

    // Drain the output register and confirm nothing was lost
    for (int i = 0; i < 3; i++) step('0, '0, '0, 1'b1, g);
    chk("drain_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
